// File: rtl/mux_pkg.sv
// Shared widths and FSM state encoding for the mux edge counter.
package mux_pkg;

  localparam int CNT_W = 8;
  localparam int WIN_W = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

endpackage

// File: rtl/bit_sync2.sv
// Two-flop synchronizer that brings an asynchronous bit into the clk domain.
module bit_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops; the first may go metastable, the second resolves it.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/mux_edge_counter.sv
// Counts rising edges of an asynchronous mux output over fixed-length windows
// and hands each window's count to a consumer over a valid/ready interface.
//
// Handshake: a result moves at any clk edge where cnt_valid & cnt_ready are
// both 1. cnt_valid is a register (never a combinational function of
// cnt_ready), stays high until that transfer, and cnt_out is frozen while it
// is high. A window closing while an unconsumed result is held is dropped
// and latches the sticky ovf flag.
module mux_edge_counter
  import mux_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             y_in,
  input  logic [WIN_W-1:0] win_len,
  output logic [CNT_W-1:0] cnt_out,
  output logic             cnt_valid,
  input  logic             cnt_ready,
  output logic             ovf,
  output logic             busy
);

  logic             y_sync;
  logic             y_dly;
  logic             rise;
  state_t           state;
  state_t           state_nxt;
  logic [WIN_W-1:0] timer;
  logic [WIN_W-1:0] timer_nxt;
  logic [CNT_W-1:0] edge_cnt;
  logic [CNT_W-1:0] edge_cnt_nxt;
  logic             close;
  logic [CNT_W-1:0] result;

  bit_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d   (y_in),
    .q   (y_sync)
  );

  // One-cycle delay of the synchronized level for edge detection.
  always_ff @(posedge clk) begin
    if (rst) y_dly <= 1'b0;
    else     y_dly <= y_sync;
  end

  assign rise = y_sync & ~y_dly;
  assign busy = (state == COUNT);

  // State, window timer and running count registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      timer    <= '0;
      edge_cnt <= '0;
    end else begin
      state    <= state_nxt;
      timer    <= timer_nxt;
      edge_cnt <= edge_cnt_nxt;
    end
  end

  // Next-state logic. win_len - 1 wraps 0 to 255, so win_len = 0 is a
  // 256-cycle window. The rise seen on the closing edge is folded into result.
  always_comb begin
    state_nxt    = state;
    timer_nxt    = timer;
    edge_cnt_nxt = edge_cnt;
    close        = 1'b0;
    result       = edge_cnt + {{(CNT_W-1){1'b0}}, rise};
    case (state)
      IDLE: begin
        edge_cnt_nxt = '0;
        if (en) begin
          state_nxt = COUNT;
          timer_nxt = win_len - {{(WIN_W-1){1'b0}}, 1'b1};
        end
      end
      COUNT: begin
        if (timer == '0) begin
          close        = 1'b1;
          edge_cnt_nxt = '0;
          if (en) timer_nxt = win_len - {{(WIN_W-1){1'b0}}, 1'b1};
          else    state_nxt = IDLE;
        end else if (!en) begin
          state_nxt    = IDLE;
          edge_cnt_nxt = '0;
          timer_nxt    = '0;
        end else begin
          edge_cnt_nxt = result;
          timer_nxt    = timer - {{(WIN_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_nxt    = IDLE;
        edge_cnt_nxt = '0;
        timer_nxt    = '0;
      end
    endcase
  end

  // Output register: load on close when empty or draining, else drop and flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_out   <= '0;
      cnt_valid <= 1'b0;
      ovf       <= 1'b0;
    end else if (close && (!cnt_valid || cnt_ready)) begin
      cnt_out   <= result;
      cnt_valid <= 1'b1;
    end else begin
      if (close)                  ovf       <= 1'b1;
      if (cnt_valid && cnt_ready) cnt_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_edge_counter.sv
// Directed self-checking bench for mux_edge_counter.
module tb_mux_edge_counter;
  import mux_pkg::*;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             en = 1'b0;
  logic             y_in = 1'b0;
  logic [WIN_W-1:0] win_len = '0;
  logic [CNT_W-1:0] cnt_out;
  logic             cnt_valid;
  logic             cnt_ready = 1'b0;
  logic             ovf;
  logic             busy;

  int checks = 0;
  int errors = 0;

  mux_edge_counter dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .y_in      (y_in),
    .win_len   (win_len),
    .cnt_out   (cnt_out),
    .cnt_valid (cnt_valid),
    .cnt_ready (cnt_ready),
    .ovf       (ovf),
    .busy      (busy)
  );

  // Clock and reset block
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic flush();
    en   = 1'b0;
    y_in = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      y_in = ~y_in;
      tick();
    end
    checks++;
    if (cnt_out !== 8'd0 || cnt_valid !== 1'b0 || ovf !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset: cnt_out=%0d valid=%b ovf=%b busy=%b expected 0/0/0/0",
               cnt_out, cnt_valid, ovf, busy);
    end
    rst = 1'b0;
    flush();
  endtask

  task automatic test_basic_count();
    logic [9:0] pat;
    pat       = 10'b00000_10101;
    win_len   = 8'd10;
    cnt_ready = 1'b1;
    en        = 1'b1;
    y_in      = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_busy: busy=%b expected 1", busy);
    end
    for (int i = 1; i <= 10; i++) begin
      y_in = pat[i-1];
      tick();
      if (i < 10) begin
        checks++;
        if (cnt_valid !== 1'b0) begin
          errors++;
          $display("FAIL basic_early_valid: edge %0d valid=%b expected 0", i, cnt_valid);
        end
      end else begin
        checks++;
        if (cnt_valid !== 1'b1 || cnt_out !== 8'd3) begin
          errors++;
          $display("FAIL basic_result: valid=%b cnt_out=%0d expected 1/3", cnt_valid, cnt_out);
        end
      end
    end
    en = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || cnt_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_drain: busy=%b valid=%b expected 0/0", busy, cnt_valid);
    end
    flush();
  endtask

  task automatic test_full_window();
    win_len   = 8'd0;
    cnt_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      y_in = ~y_in;
      tick();
    end
    en   = 1'b1;
    y_in = ~y_in;
    tick();
    for (int i = 1; i <= 256; i++) begin
      y_in = ~y_in;
      tick();
      if (i == 255) begin
        checks++;
        if (cnt_valid !== 1'b0) begin
          errors++;
          $display("FAIL full_early_valid: valid=%b expected 0", cnt_valid);
        end
      end
    end
    checks++;
    if (cnt_valid !== 1'b1 || cnt_out !== 8'd128) begin
      errors++;
      $display("FAIL full_result: valid=%b cnt_out=%0d expected 1/128", cnt_valid, cnt_out);
    end
    flush();
  endtask

  task automatic test_back_to_back();
    win_len   = 8'd1;
    cnt_ready = 1'b1;
    en        = 1'b1;
    y_in      = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b1 || cnt_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_entry: busy=%b valid=%b expected 1/0", busy, cnt_valid);
    end
    for (int m = 1; m <= 8; m++) begin
      y_in = ~y_in;
      tick();
      checks++;
      if (cnt_valid !== 1'b1 || ovf !== 1'b0 || busy !== 1'b1 ||
          cnt_out !== ((m % 2 == 0) ? 8'd1 : 8'd0)) begin
        errors++;
        $display("FAIL b2b_cycle: edge %0d valid=%b ovf=%b busy=%b cnt_out=%0d expected 1/0/1/%0d",
                 m, cnt_valid, ovf, busy, cnt_out, (m % 2 == 0) ? 1 : 0);
      end
    end
    flush();
  endtask

  task automatic test_backpressure();
    logic [7:0] pat;
    pat       = 8'b1111_0010;
    win_len   = 8'd4;
    cnt_ready = 1'b0;
    en        = 1'b1;
    y_in      = 1'b1;
    tick();
    for (int i = 1; i <= 8; i++) begin
      y_in = pat[i-1];
      tick();
      if (i == 4) begin
        checks++;
        if (cnt_valid !== 1'b1 || cnt_out !== 8'd2 || ovf !== 1'b0) begin
          errors++;
          $display("FAIL bp_first: valid=%b cnt_out=%0d ovf=%b expected 1/2/0",
                   cnt_valid, cnt_out, ovf);
        end
      end
    end
    checks++;
    if (cnt_valid !== 1'b1 || cnt_out !== 8'd2 || ovf !== 1'b1) begin
      errors++;
      $display("FAIL bp_second: valid=%b cnt_out=%0d ovf=%b expected 1/2/1",
               cnt_valid, cnt_out, ovf);
    end
    en        = 1'b0;
    y_in      = 1'b0;
    cnt_ready = 1'b1;
    tick();
    checks++;
    if (cnt_valid !== 1'b0 || ovf !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_drain: valid=%b ovf=%b busy=%b expected 0/1/0", cnt_valid, ovf, busy);
    end
    repeat (3) tick();
    checks++;
    if (ovf !== 1'b1) begin
      errors++;
      $display("FAIL bp_sticky: ovf=%b expected 1", ovf);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (ovf !== 1'b0) begin
      errors++;
      $display("FAIL bp_ovf_clear: ovf=%b expected 0", ovf);
    end
    flush();
  endtask

  task automatic test_abort();
    logic [5:0] pat;
    int         seen;
    pat       = 6'b000101;
    win_len   = 8'd20;
    cnt_ready = 1'b1;
    en        = 1'b1;
    y_in      = 1'b0;
    tick();
    for (int i = 1; i <= 6; i++) begin
      y_in = pat[i-1];
      tick();
    end
    en   = 1'b0;
    y_in = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_busy: busy=%b expected 0", busy);
    end
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (cnt_valid !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL abort_no_result: valid cycles=%0d expected 0", seen);
    end
    // Reset in the middle of a window, then start a fresh one.
    en = 1'b1;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0 || cnt_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_abort: busy=%b valid=%b expected 0/0", busy, cnt_valid);
    end
    win_len = 8'd2;
    rst     = 1'b0;
    tick();
    tick();
    checks++;
    if (busy !== 1'b1 || cnt_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_restart_mid: busy=%b valid=%b expected 1/0", busy, cnt_valid);
    end
    tick();
    checks++;
    if (cnt_valid !== 1'b1 || cnt_out !== 8'd0) begin
      errors++;
      $display("FAIL rst_restart_result: valid=%b cnt_out=%0d expected 1/0", cnt_valid, cnt_out);
    end
    flush();
  endtask

  initial begin
    test_reset();
    test_basic_count();
    test_full_window();
    test_back_to_back();
    test_backpressure();
    test_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_edge_counter.md
MUX_EDGE_COUNTER -- requirements
Module: mux_edge_counter

Interface
REQ-001 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, sole clock; all state updates on the rising edge.
- rst, in, 1, synchronous active-high reset.
- en, in, 1, counting enable.
- y_in, in, 1, asynchronous 2:1 mux output y being monitored.
- win_len, in, 8, window length in clk cycles; 0 means 256.
- cnt_out, out, 8, rising-edge count of the last completed window.
- cnt_valid, out, 1, cnt_out holds an unconsumed result.
- cnt_ready, in, 1, consumer accepts the result.
- ovf, out, 1, sticky flag: a result was dropped.
- busy, out, 1, high while a window is open.
REQ-002 The block SHALL use one clock, clk, with a synchronous active-high reset, rst; no other clock or reset SHALL exist.

Function
REQ-003 y_in SHALL pass through a 2-flop synchronizer, then a 1-flop delay; rise = sync2 & ~delay.
REQ-004 A y_in rising edge first sampled at clock edge k SHALL be counted at edge k+2.
REQ-005 The FSM SHALL have exactly two states, IDLE and COUNT, and busy SHALL equal (state == COUNT).
REQ-006 In IDLE: edge_cnt = 0, and no counting occurs.
REQ-007 IDLE to COUNT: at an edge with en = 1, the block SHALL load timer with win_len-1 (win_len = 0 loads 255).
REQ-008 In COUNT, each edge SHALL:
- increment edge_cnt when rise = 1;
- decrement timer when timer != 0.
REQ-009 The edge where timer == 0 SHALL close the window. The window therefore spans exactly L edges, where L = win_len, or 256 when win_len = 0.
REQ-010 At a window close, the result SHALL be edge_cnt + rise.
REQ-011 8 bits SHALL suffice: at most 128 rises occur in 256 cycles, so no saturation logic is required.
REQ-012 At a window close with en = 1, the block SHALL stay in COUNT, clear edge_cnt and reload timer in the same edge, with no gap cycle.
REQ-013 At a window close with en = 0, the block SHALL go to IDLE after delivering the result.
REQ-014 If en = 0 in COUNT before the close edge, the block SHALL go to IDLE at the next edge, discard the partial count and produce no result.
REQ-015 Handshake: a transfer SHALL occur at an edge with cnt_valid & cnt_ready. Handshake rules:
- While cnt_valid = 1, cnt_out SHALL be held stable.
- cnt_valid SHALL stay high until a transfer.
- cnt_valid SHALL NOT depend combinationally on cnt_ready.
REQ-016 Window close while the output register is empty, or a transfer occurs in the same edge: the new result SHALL load into cnt_out and cnt_valid SHALL be 1.
REQ-017 Window close while cnt_valid = 1 and no transfer occurs: the new result SHALL be dropped, cnt_out SHALL keep the old value and ovf SHALL be set.
REQ-018 ovf SHALL remain 1 until rst.
REQ-019 Changes to win_len SHALL take effect only at the next timer load.

Reset
REQ-020 While rst = 1 at an edge, the block SHALL set:
- state = IDLE;
- timer = 0, edge_cnt = 0;
- synchronizer and delay flops = 0;
- cnt_out = 0, cnt_valid = 0, ovf = 0, busy = 0.
REQ-021 rst mid-window SHALL abort the window with no result. After rst falls, en = 1 SHALL start a fresh window.

Structure
REQ-022 A shared package mux_pkg SHALL hold CNT_W = 8, WIN_W = 8 and the state enum (IDLE, COUNT).
REQ-023 The 2-flop synchronizer SHALL be a separate sub-module, bit_sync2, instantiated once.

Verification
REQ-024 The bench SHALL cover these scenarios:
- Reset: rst = 1 for 2 cycles with y_in toggling -> all outputs 0; ovf = 0.
- Basic count: win_len = 10, en = 1, cnt_ready = 1, 3 clean rises on y_in within the window -> one cnt_valid with cnt_out = 3 at the 10th edge after COUNT entry.
- Full window: win_len = 0, y_in a free-running clk/2 square wave before en -> cnt_out = 128 after 256 cycles.
- Backpressure: win_len = 4, cnt_ready = 0, distinct counts 2 then 1 -> cnt_out stays 2, ovf = 1 after the second close, ovf stays 1 after cnt_ready = 1.
- Back-to-back: win_len = 1, cnt_ready = 1 held, en = 1 -> cnt_valid stays 1 every cycle, ovf stays 0.
- Abort: win_len = 20, en dropped at cycle 7 with 2 rises seen -> busy = 0 the next cycle, cnt_valid never asserts.
